// File: rtl/conv_pkg.sv
// Shared constants and types for the 14x14 convolution stage and its neighbours.
package conv_pkg;

    localparam int IMG_DIM  = 14;
    localparam int NUM_PIX  = IMG_DIM * IMG_DIM;
    localparam int INT_SIZE = 8;
    localparam int IDX_W    = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Stride between neighbouring pixels in any flattened pixel vector.
    localparam int PIX_SLICE = INT_SIZE;

    function automatic int pix_lsb(input int p);
        return p * PIX_SLICE;
    endfunction

endpackage

// File: rtl/conv14_scan_ctrl_relu.sv
// Combinational signed clamp: negative values become zero when enabled.
module relu_clamp #(
    parameter int W       = conv_pkg::INT_SIZE,
    parameter bit RELU_EN = 1'b1
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (RELU_EN) begin : g_clamp
            assign dout = din[W-1] ? '0 : din;
        end else begin : g_pass
            assign dout = din;
        end
    endgenerate

endmodule

// File: rtl/conv14_scan_ctrl.sv
// Steps the convolution position index through a full image and collects
// each (optionally rectified) result into a flattened feature-map buffer.
module conv14_scan_ctrl #(
    parameter int IMG_DIM  = conv_pkg::IMG_DIM,
    parameter int INT_SIZE = conv_pkg::INT_SIZE,
    parameter int IDX_W    = conv_pkg::IDX_W,
    parameter bit RELU_EN  = 1'b1,
    localparam int NUM_PIX = IMG_DIM * IMG_DIM
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        fmap_valid,
    output logic [IDX_W-1:0]            dp_state,
    input  logic [INT_SIZE-1:0]         conv_out,
    output logic [NUM_PIX*INT_SIZE-1:0] fmap
);
    import conv_pkg::scan_state_t;
    import conv_pkg::IDLE;
    import conv_pkg::RUN;
    import conv_pkg::DONE;

    localparam int CNT_W = $clog2(NUM_PIX);

    scan_state_t          state_reg, state_next;
    logic [CNT_W-1:0]     pos_reg, pos_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic                 valid_reg, valid_next;
    logic                 wr_en;
    logic [INT_SIZE-1:0]  pix_in;

    relu_clamp #(
        .W       (INT_SIZE),
        .RELU_EN (RELU_EN)
    ) u_relu (
        .din  (conv_out),
        .dout (pix_in)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            pos_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            valid_reg <= valid_next;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        valid_next = valid_reg;
        wr_en      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    pos_next   = '0;
                    busy_next  = 1'b1;
                    valid_next = 1'b0;
                end
            end
            RUN: begin
                wr_en = 1'b1;
                if (pos_reg == CNT_W'(NUM_PIX - 1)) begin
                    state_next = DONE;
                    pos_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    pos_next = pos_reg + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                valid_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
                pos_next   = '0;
                busy_next  = 1'b0;
                valid_next = 1'b0;
            end
        endcase
    end

    // Every entry is visible at once on the fmap bus, so the buffer is flops, not RAM.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PIX; gi++) begin : g_pix
            logic [INT_SIZE-1:0] pix_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pix_reg <= '0;
                end else if (wr_en && (pos_reg == CNT_W'(gi))) begin
                    pix_reg <= pix_in;
                end
            end

            assign fmap[gi*INT_SIZE +: INT_SIZE] = pix_reg;
        end
    endgenerate

    assign dp_state   = IDX_W'(pos_reg);
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign fmap_valid = valid_reg;

endmodule
